// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle synchronous imem,
// stall hold of the presented instruction, and redirect restart.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  logic [31:0] fetch_pc;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic        hold_valid;
  logic [31:0] hold_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      hold_valid <= 1'b0;
      hold_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      // Capture on the first stalled edge only; the memory output may drift afterwards.
      if (resp_valid && !hold_valid) begin
        hold_inst  <= imem_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      resp_valid <= 1'b1;
      resp_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + 32'd4;
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    imem_addr = fetch_pc;
    imem_en   = ~rst & (~stall | redirect_valid);
    if_valid  = ~rst & resp_valid;
    if_pc     = resp_pc;
    if_inst   = NOP_INST;
    if (!rst && resp_valid) begin
      if_inst = hold_valid ? hold_inst : imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a synchronous memory returning addr^KEY
// (garbage when no request was issued) and a queue of expected PCs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic [31:0] mem_q = '0;
  logic        mem_ok = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_pc = RESET_PC;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  // Memory output is only meaningful in the cycle after an issued request.
  always @(posedge clk) begin
    mem_ok <= imem_en;
    if (imem_en) mem_q <= imem_addr ^ KEY;
  end
  assign imem_rdata = mem_ok ? mem_q : GARBAGE;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic rv, input logic [31:0] rpc);
    logic exp_valid;
    @(posedge clk);
    #1;
    rst = r;
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(negedge clk);
    exp_valid = !r && (exp_q.size() > 0);
    check("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    check("imem_en", {31'b0, imem_en}, {31'b0, (!r && (!st || rv))});
    if (!r) check("imem_addr", imem_addr, m_pc);
    if (exp_valid) begin
      check("if_pc", if_pc, exp_q[0]);
      check("if_inst", if_inst, exp_q[0] ^ KEY);
    end else begin
      check("if_inst_nop", if_inst, NOP_INST);
    end
    if (exp_valid && !st && !rv) void'(exp_q.pop_front());
    if (r) begin
      exp_q.delete();
      m_pc = RESET_PC;
    end else if (rv) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (!st) begin
      exp_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    // Reset release: issue, then first instruction.
    cycle(0, 0, 0, 0);
    check("rel_valid", {31'b0, if_valid}, 32'd0);
    check("rel_addr", imem_addr, 32'h4000_0000);
    cycle(0, 0, 0, 0);
    check("first_pc", if_pc, 32'h4000_0000);
    check("first_inst", if_inst, 32'hE5A5_0000);
    cycle(0, 0, 0, 0);
    // Three stalled cycles with 4000_0008 presented; memory goes to garbage.
    repeat (3) begin
      cycle(0, 1, 0, 0);
      check("stall_pc", if_pc, 32'h4000_0008);
      check("stall_inst", if_inst, 32'h4000_0008 ^ KEY);
      check("stall_fetch", imem_addr, 32'h4000_000C);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("post_stall_pc", if_pc, 32'h4000_000C);
    cycle(0, 0, 0, 0);
    // Redirect with misaligned target.
    cycle(0, 0, 1, 32'h4000_0103);
    cycle(0, 0, 0, 0);
    check("redir_n1_addr", imem_addr, 32'h4000_0100);
    check("redir_n1_valid", {31'b0, if_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    check("redir_n2_pc", if_pc, 32'h4000_0100);
    cycle(0, 0, 0, 0);
    // Redirect and stall together, stall continues afterwards.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h4000_0200);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("redir_stall_pc", if_pc, 32'h4000_0200);
    cycle(0, 0, 0, 0);
    // Address wrap.
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    check("wrap_pc1", if_pc, 32'h0000_0000);
    cycle(0, 0, 0, 0);
    // Reset pulse while holding a stalled instruction.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("rst_hold_valid", {31'b0, if_valid}, 32'd0);
    check("rst_hold_addr", imem_addr, 32'h4000_0000);
    cycle(0, 0, 0, 0);
    check("rst_hold_pc", if_pc, 32'h4000_0000);
    check("rst_hold_inst", if_inst, 32'hE5A5_0000);
    // Random mix of stalls and redirects.
    for (int i = 0; i < 60; i++) begin
      cycle(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
